// File: rtl/isqrt_rr_share.sv
// Round-robin front end sharing one pipelined integer square root among N requesters.
// A tag line matched to the root pipeline returns each result with its requester ID.
module isqrt_rr_share #(
  parameter int unsigned N         = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned ISQRT_LAT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_vld,
  input  logic [N*32-1:0]   req_x,
  output logic [N-1:0]      req_rdy,
  output logic              res_vld,
  output logic [ID_W-1:0]   res_id,
  output logic [31:0]       res,
  output logic              busy,
  output logic              err
);

  // Arbitration
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] grant_id;
  logic            grant_any;

  always_comb begin
    int unsigned idx;
    idx       = 0;
    req_rdy   = '0;
    grant_id  = ptr_q;
    grant_any = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!grant_any && req_vld[ID_W'(idx)]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
    if (grant_any) req_rdy[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)            ptr_q <= ID_W'(N - 1);
    else if (grant_any) ptr_q <= grant_id;
  end

  // Operand mux; x holds its last value on idle cycles to avoid toggling the pipeline.
  logic [31:0] x_q;
  logic [31:0] isqrt_x;
  logic        isqrt_x_vld;

  always_comb begin
    isqrt_x_vld = grant_any;
    isqrt_x     = x_q;
    for (int i = 0; i < int'(N); i++) begin
      if (req_rdy[i]) isqrt_x = req_x[32*i +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)              x_q <= '0;
    else if (isqrt_x_vld) x_q <= isqrt_x;
  end

  // Root pipeline: one result bit per stage, so ISQRT_LAT must be 16 for a 32-bit radicand.
  logic [ISQRT_LAT-1:0] sq_vld_q;
  logic [ISQRT_LAT-1:0] sq_vld_in;
  logic [15:0] sq_rem_q   [ISQRT_LAT];
  logic [15:0] sq_rem_in  [ISQRT_LAT];
  logic [15:0] sq_rem_d   [ISQRT_LAT];
  logic [15:0] sq_root_q  [ISQRT_LAT];
  logic [15:0] sq_root_in [ISQRT_LAT];
  logic [15:0] sq_root_d  [ISQRT_LAT];
  logic [31:0] sq_xs_q    [ISQRT_LAT];
  logic [31:0] sq_xs_in   [ISQRT_LAT];
  logic [31:0] sq_xs_d    [ISQRT_LAT];

  // Tag line
  logic [ISQRT_LAT-1:0] tag_vld_q;
  logic [ISQRT_LAT-1:0] tag_vld_in;
  logic [ID_W-1:0]      tag_id_q  [ISQRT_LAT];
  logic [ID_W-1:0]      tag_id_in [ISQRT_LAT];

  assign sq_vld_in  = {sq_vld_q[ISQRT_LAT-2:0], isqrt_x_vld};
  assign tag_vld_in = {tag_vld_q[ISQRT_LAT-2:0], grant_any};

  for (genvar s = 0; s < ISQRT_LAT; s++) begin : g_link
    if (s == 0) begin : g_head
      assign sq_rem_in[s]  = '0;
      assign sq_root_in[s] = '0;
      assign sq_xs_in[s]   = isqrt_x;
      assign tag_id_in[s]  = grant_id;
    end else begin : g_tail
      assign sq_rem_in[s]  = sq_rem_q[s-1];
      assign sq_root_in[s] = sq_root_q[s-1];
      assign sq_xs_in[s]   = sq_xs_q[s-1];
      assign tag_id_in[s]  = tag_id_q[s-1];
    end
  end

  always_comb begin
    logic [17:0] rem_sh;
    logic [17:0] trial;
    rem_sh = '0;
    trial  = '0;
    for (int s = 0; s < int'(ISQRT_LAT); s++) begin
      rem_sh     = {sq_rem_in[s], sq_xs_in[s][31:30]};
      trial      = {sq_root_in[s], 2'b01};
      sq_xs_d[s] = {sq_xs_in[s][29:0], 2'b00};
      // Remainder stays below 2^16 for every stage whose remainder is consumed.
      if (rem_sh >= trial) begin
        sq_rem_d[s]  = 16'(rem_sh - trial);
        sq_root_d[s] = {sq_root_in[s][14:0], 1'b1};
      end else begin
        sq_rem_d[s]  = rem_sh[15:0];
        sq_root_d[s] = {sq_root_in[s][14:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sq_vld_q  <= '0;
      tag_vld_q <= '0;
    end else begin
      sq_vld_q  <= sq_vld_in;
      tag_vld_q <= tag_vld_in;
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < int'(ISQRT_LAT); s++) begin
      if (sq_vld_in[s]) begin
        sq_rem_q[s]  <= sq_rem_d[s];
        sq_root_q[s] <= sq_root_d[s];
        sq_xs_q[s]   <= sq_xs_d[s];
      end
      if (tag_vld_in[s]) tag_id_q[s] <= tag_id_in[s];
    end
  end

  // Output register
  logic        y_vld;
  logic [15:0] y;
  logic        tag_out_vld;

  assign y_vld       = sq_vld_q[ISQRT_LAT-1];
  assign y           = sq_root_q[ISQRT_LAT-1];
  assign tag_out_vld = tag_vld_q[ISQRT_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld <= 1'b0;
      res_id  <= '0;
      res     <= '0;
      err     <= 1'b0;
    end else begin
      res_vld <= tag_out_vld;
      if (tag_out_vld) begin
        res    <= {16'b0, y};
        res_id <= tag_id_q[ISQRT_LAT-1];
      end
      if (y_vld != tag_out_vld) err <= 1'b1;
    end
  end

  assign busy = (|tag_vld_q) | res_vld;

endmodule

// File: tb/tb_isqrt_rr_share.sv
// Directed and scoreboarded checks for the shared round-robin isqrt front end.
module tb_isqrt_rr_share;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_vld = '0;
  logic [127:0] req_x = '0;
  logic [3:0]   req_rdy;
  logic         res_vld;
  logic [1:0]   res_id;
  logic [31:0]  res;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  isqrt_rr_share #(.N(4), .ID_W(2), .ISQRT_LAT(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_x   (req_x),
    .req_rdy (req_rdy),
    .res_vld (res_vld),
    .res_id  (res_id),
    .res     (res),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] root;
    int          due;
  } exp_t;

  function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= 64'(x)) lo = mid;
      else hi = mid - 1;
    end
    return lo[31:0];
  endfunction

  task automatic set_x(input int i, input logic [31:0] v);
    req_x[32*i +: 32] = v;
  endtask

  // Leaves the bench on a negedge with rst just released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_vld = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (res_vld !== 1'b0) begin n_fail++; $display("FAIL rst_res_vld got %0b want 0", res_vld); end
    n_checks++; if (res_id !== 2'd0) begin n_fail++; $display("FAIL rst_res_id got %0d want 0", res_id); end
    n_checks++; if (res !== 32'd0) begin n_fail++; $display("FAIL rst_res got %0d want 0", res); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %0b want 0", err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b want 0", busy); end
    #1;
    n_checks++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL rst_rdy_idle got %b want 0000", req_rdy); end
    req_vld = 4'hf;
    #1;
    n_checks++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL rst_ptr got %b want 0001", req_rdy); end
    req_vld = 4'h0;
    #1;
    n_checks++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL rst_rdy_drop got %b want 0000", req_rdy); end
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 0; k < 26; k++) begin
      n_checks++;
      if (res_vld !== (k == 17)) begin
        n_fail++; $display("FAIL single_vld k=%0d got %0b want %0b", k, res_vld, (k == 17));
      end
      if (k == 17) begin
        n_checks++; if (res_id !== 2'd2 || res !== 32'd12) begin
          n_fail++; $display("FAIL single_res got id=%0d res=%0d want id=2 res=12", res_id, res);
        end
      end
      if (k == 0) begin
        req_vld = 4'b0100;
        set_x(2, 32'd144);
        #1;
        n_checks++; if (req_rdy !== 4'b0100) begin n_fail++; $display("FAIL single_rdy got %b want 0100", req_rdy); end
      end else begin
        req_vld = '0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_all();
    logic [31:0] xs [4];
    logic [31:0] roots [4];
    logic [3:0]  exp_rdy;
    xs    = '{32'd0, 32'd1, 32'hffff_ffff, 32'd1000000};
    roots = '{32'd0, 32'd1, 32'd65535, 32'd1000};
    do_reset();
    for (int i = 0; i < 4; i++) set_x(i, xs[i]);
    for (int k = 0; k < 31; k++) begin
      n_checks++;
      if (res_vld !== (k >= 17 && k <= 24)) begin
        n_fail++; $display("FAIL all_vld k=%0d got %0b", k, res_vld);
      end
      if (k >= 17 && k <= 24) begin
        n_checks++;
        if (res_id !== 2'((k - 17) % 4) || res !== roots[(k - 17) % 4]) begin
          n_fail++; $display("FAIL all_res k=%0d got id=%0d res=%0d want id=%0d res=%0d",
                             k, res_id, res, (k - 17) % 4, roots[(k - 17) % 4]);
        end
      end
      if (k < 8) begin
        req_vld = 4'hf;
        exp_rdy = 4'(1 << (k % 4));
        #1;
        n_checks++; if (req_rdy !== exp_rdy) begin
          n_fail++; $display("FAIL all_rdy k=%0d got %b want %b", k, req_rdy, exp_rdy);
        end
      end else begin
        req_vld = '0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rdy [6];
    exp_rdy = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0001, 4'b0010};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req_vld = {1'b1, 1'b0, 1'b1, (k >= 3)};
      #1;
      n_checks++; if (req_rdy !== exp_rdy[k]) begin
        n_fail++; $display("FAIL fair_rdy k=%0d got %b want %b", k, req_rdy, exp_rdy[k]);
      end
      @(negedge clk);
    end
    req_vld = '0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_gaps();
    logic exp_v;
    do_reset();
    set_x(0, 32'd81);
    for (int k = 0; k < 31; k++) begin
      exp_v = (k >= 17 && k <= 26 && (k - 17) % 3 == 0);
      n_checks++; if (res_vld !== exp_v) begin
        n_fail++; $display("FAIL gap_vld k=%0d got %0b want %0b", k, res_vld, exp_v);
      end
      if (exp_v) begin
        n_checks++; if (res !== 32'd9 || res_id !== 2'd0) begin
          n_fail++; $display("FAIL gap_res k=%0d got id=%0d res=%0d want id=0 res=9", k, res_id, res);
        end
      end
      n_checks++; if (busy !== (k >= 1 && k <= 26)) begin
        n_fail++; $display("FAIL gap_busy k=%0d got %0b want %0b", k, busy, (k >= 1 && k <= 26));
      end
      if (k < 12 && k % 3 == 0) begin
        req_vld = 4'b0001;
        #1;
        n_checks++; if (req_rdy !== 4'b0001) begin
          n_fail++; $display("FAIL gap_rdy k=%0d got %b want 0001", k, req_rdy);
        end
      end else begin
        req_vld = '0;
        if (k < 12) begin
          #1;
          n_checks++; if (dut.isqrt_x !== 32'd81) begin
            n_fail++; $display("FAIL gap_x_hold k=%0d got %0d want 81", k, dut.isqrt_x);
          end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) set_x(i, 32'd49);
    for (int k = 0; k < 28; k++) begin
      if (k >= 8) begin
        n_checks++; if (res_vld !== 1'b0 || err !== 1'b0) begin
          n_fail++; $display("FAIL mid_flush k=%0d got vld=%0b err=%0b want 0 0", k, res_vld, err);
        end
      end
      if (k == 8) begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %0b want 0", busy); end
      end
      rst = (k == 7);
      if (k < 3) begin
        req_vld = 4'hf;
        #1;
        n_checks++; if (req_rdy !== 4'(1 << k)) begin
          n_fail++; $display("FAIL mid_rdy k=%0d got %b want %b", k, req_rdy, 4'(1 << k));
        end
      end else begin
        req_vld = '0;
      end
      @(negedge clk);
    end
    req_vld = 4'hf;
    #1;
    n_checks++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr got %b want 0001", req_rdy); end
    req_vld = '0;
  endtask

  task automatic test_boundary();
    logic [31:0] vals [5];
    logic [31:0] roots [5];
    logic        exp_v;
    vals  = '{32'd0, 32'd1, 32'd3, 32'd4, 32'hffff_ffff};
    roots = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd65535};
    do_reset();
    for (int k = 0; k < 26; k++) begin
      exp_v = (k >= 17 && k <= 21);
      n_checks++; if (res_vld !== exp_v) begin
        n_fail++; $display("FAIL bnd_vld k=%0d got %0b want %0b", k, res_vld, exp_v);
      end
      if (exp_v) begin
        n_checks++; if (res !== roots[k - 17] || res_id !== 2'd0) begin
          n_fail++; $display("FAIL bnd_res k=%0d got id=%0d res=%0d want id=0 res=%0d",
                             k, res_id, res, roots[k - 17]);
        end
      end
      if (k < 5) begin
        req_vld = 4'b0001;
        set_x(0, vals[k]);
        #1;
        n_checks++; if (req_rdy !== 4'b0001) begin
          n_fail++; $display("FAIL bnd_rdy k=%0d got %b want 0001", k, req_rdy);
        end
      end else begin
        req_vld = '0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    exp_t        q [$];
    exp_t        e;
    logic [1:0]  ptr;
    logic [3:0]  exp_rdy;
    logic [1:0]  idx;
    logic        found;
    logic [31:0] xv;
    do_reset();
    ptr = 2'd3;
    for (int cyc = 0; cyc < 10020; cyc++) begin
      n_checks++;
      if (q.size() > 0 && q[0].due == cyc) begin
        if (res_vld !== 1'b1 || res_id !== q[0].id || res !== q[0].root) begin
          n_fail++; $display("FAIL rnd_res cyc=%0d got vld=%0b id=%0d res=%0d want id=%0d res=%0d",
                             cyc, res_vld, res_id, res, q[0].id, q[0].root);
        end
        void'(q.pop_front());
      end else if (res_vld !== 1'b0) begin
        n_fail++; $display("FAIL rnd_spurious cyc=%0d got vld=%0b want 0", cyc, res_vld);
      end
      if (cyc < 10000) begin
        req_vld = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
          xv = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
          set_x(i, xv);
        end
        exp_rdy = '0;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          idx = 2'((32'(ptr) + 32'(k)) % 4);
          if (!found && req_vld[idx]) begin
            found        = 1'b1;
            exp_rdy[idx] = 1'b1;
            e.id   = idx;
            e.root = ref_sqrt(req_x[32*idx +: 32]);
            e.due  = cyc + 17;
          end
        end
        #1;
        n_checks++; if (req_rdy !== exp_rdy) begin
          n_fail++; $display("FAIL rnd_rdy cyc=%0d got %b want %b", cyc, req_rdy, exp_rdy);
        end
        if (found) begin
          q.push_back(e);
          ptr = e.id;
        end
      end else begin
        req_vld = '0;
      end
      @(negedge clk);
    end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain got %0d left want 0", q.size()); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rnd_err got %0b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all();
    test_fairness();
    test_gaps();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
